data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single-port data memory bus between two requesters:
  - Port A: the RISC-V core load/store path.
  - Port B: a secondary master (DMA or debug).
- Sits between the requesters and the data memory bus inside the toplevel.
- Fixed priority to A, with a starvation guard and an atomic lock for B.
- Read data is registered and returned one cycle after the grant, with a per-port valid pulse.

Parameters:
- STARVE_LIMIT, 8: number of consecutive cycles B may wait before it outranks A. Legal range 1..255.

Ports:
- clock  in  1  global clock, rising edge
- reset  in  1  asynchronous, active-low reset
- a_req  in  1  port A request
- a_addr  in  32  port A byte address
- a_wdata  in  32  port A write data
- a_be  in  4  port A byte enables
- a_we  in  1  port A transfer type: 1 = write, 0 = read
- a_gnt  out  1  port A request accepted this cycle
- a_rvalid  out  1  port A read data valid (one-cycle pulse)
- a_rdata  out  32  port A read data
- b_req, b_addr, b_wdata, b_be, b_we, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- b_lock  in  1  B requests that it keep ownership after this access
- mem_address  out  32  to data memory bus
- mem_write_data  out  32  to data memory bus
- mem_byte_enable  out  4  to data memory bus
- mem_read_enable  out  1  to data memory bus
- mem_write_enable  out  1  to data memory bus
- mem_read_data  in  32  from data memory bus; combinational on mem_address
- owner  out  2  requester granted this cycle: 00 none, 01 A, 10 B

Behaviour:
- Grant is combinational, in the same cycle as the request. A transfer is accepted when req && gnt. At most one of a_gnt/b_gnt is high in any cycle.
- Winner selection, priority order:
  1. lock_held && b_req → B.
  2. starve_cnt == STARVE_LIMIT && b_req → B.
  3. a_req → A.
  4. b_req → B.
  5. Otherwise, none.
- mem_* outputs are muxed combinationally from the winner:
  - mem_read_enable = winner & !we; mem_write_enable = winner & we.
  - With no winner: all mem_* = 0, owner = 00.
- Writes commit at the memory's clock edge. The arbiter adds no latency.
- Reads:
  - mem_read_data is sampled at the end of the grant cycle into the winner's rdata register.
  - That port's rvalid is high for exactly the following cycle.
  - rdata holds its value until that port's next read completes. Writes do not pulse rvalid or change rdata.
- Back-to-back accesses: a new grant is allowed in the same cycle as the previous rvalid. Single-cycle throughput.
- starve_cnt (8-bit register):
  - Clears to 0 when B is granted or b_req = 0.
  - Otherwise increments while b_req && !b_gnt.
  - Saturates at STARVE_LIMIT.
- lock_held (register):
  - Set at the edge of a B grant with b_lock = 1.
  - Cleared at the edge of a B grant with b_lock = 0, or any cycle with b_req = 0.
  - While lock_held = 1, A is blocked even with A requesting.
- Asynchronous reset (reset = 0):
  - Immediately clears a_rvalid, b_rvalid, a_rdata, b_rdata, starve_cnt and lock_held.
  - Forces a_gnt = b_gnt = 0, all mem_* outputs = 0, owner = 00.
- A read granted in the cycle reset asserts produces no rvalid. On reset release, the first grant follows the normal rules with A priority.
- Simultaneous events:
  - When A and B both request with starve_cnt < STARVE_LIMIT and no lock, A wins.
  - When a locked B drops b_req, lock_held clears at that edge. In the same cycle, A may be granted combinationally, because B is not requesting.

Test Plan:
- Read pass-through: A read addr 0x100, memory word 0xDEADBEEF → a_gnt=1 in cycle 0; a_rvalid=1 and a_rdata=0xDEADBEEF in cycle 1; b_rvalid stays 0.
- Write then read: A writes 0x12345678 to 0x40 with be=0xF, then B reads 0x40 → B gets 0x12345678 with b_rvalid one cycle after b_gnt.
- Starvation: A and B both request continuously, STARVE_LIMIT=8 → A granted cycles 0-7, B granted cycle 8, A granted cycle 9. Pattern repeats every 9 cycles.
- Lock: B reads with b_lock=1, next cycle writes with b_lock=0, A requesting throughout → B granted both cycles, A granted third cycle.
- Mid-operation reset: assert reset low in the cycle of an A read grant → a_rvalid=0, all mem_* enables 0 immediately; after release, a fresh A request is granted normally.
- Idle: no requests for 5 cycles → owner=00, all mem_* = 0, both rvalid = 0, starve_cnt = 0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Shares one single-port data memory bus between two masters:
//   port A - core load/store path (normally highest priority)
//   port B - secondary master (DMA / debug)
//
// A wins by default. B is protected from starvation by a wait counter that
// lets it outrank A once it has waited STARVE_LIMIT cycles, and B can hold
// the bus across consecutive accesses with b_lock. Grants and the memory bus
// mux are combinational. Read data is captured at the end of the grant cycle
// and presented with a one-cycle rvalid pulse on the owning port.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   a_req/a_addr/a_wdata/a_be/a_we   port A request
//   a_gnt, a_rvalid, a_rdata         port A grant and registered read return
//   b_* (same as A) plus b_lock      port B request, b_lock keeps ownership
//   mem_address, mem_write_data, mem_byte_enable,
//   mem_read_enable, mem_write_enable  memory bus, driven from the winner
//   mem_read_data                    memory read data (combinational on address)
//   owner                            00 none, 01 A, 10 B
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        a_req,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_be,
    input  logic        a_we,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_be,
    input  logic        b_we,
    input  logic        b_lock,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data,

    output logic [1:0]  owner
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        lock_held_q,  lock_held_d;
    logic        a_rvalid_q,   a_rvalid_d;
    logic        b_rvalid_q,   b_rvalid_d;
    logic [31:0] a_rdata_q,    a_rdata_d;
    logic [31:0] b_rdata_q,    b_rdata_d;

    logic grant_a;
    logic grant_b;

    // Winner selection. Gated by reset so that while reset is held low the
    // bus is quiet immediately, without waiting for a clock edge.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset) begin
            if (b_req && (lock_held_q || (starve_cnt_q == LIMIT))) begin
                grant_b = 1'b1;
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    // Memory bus mux: everything is zero when nobody owns the bus.
    always_comb begin
        mem_address      = 32'd0;
        mem_write_data   = 32'd0;
        mem_byte_enable  = 4'd0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        if (grant_a) begin
            mem_address      = a_addr;
            mem_write_data   = a_wdata;
            mem_byte_enable  = a_be;
            mem_read_enable  = !a_we;
            mem_write_enable = a_we;
        end else if (grant_b) begin
            mem_address      = b_addr;
            mem_write_data   = b_wdata;
            mem_byte_enable  = b_be;
            mem_read_enable  = !b_we;
            mem_write_enable = b_we;
        end
    end

    // Next-state for the starvation counter, lock and read return registers.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        lock_held_d  = lock_held_q;
        a_rvalid_d   = 1'b0;
        b_rvalid_d   = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        // Counter only runs while B is actually waiting; it saturates so B
        // keeps its priority claim until served.
        if (!b_req || grant_b) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        // Dropping the request always releases the lock; otherwise each B
        // grant re-decides ownership from its own b_lock.
        if (!b_req) begin
            lock_held_d = 1'b0;
        end else if (grant_b) begin
            lock_held_d = b_lock;
        end

        if (grant_a && !a_we) begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = mem_read_data;
        end
        if (grant_b && !b_we) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = mem_read_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 8'd0;
            lock_held_q  <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= 32'd0;
            b_rdata_q    <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            lock_held_q  <= lock_held_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_gnt    = grant_a;
    assign b_gnt    = grant_b;
    assign owner    = {grant_b, grant_a};
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for data_bus_arbiter. A small word memory sits on the mem_* bus.
// A transaction-level model (wait count, lock flag, shadow memory, pending
// read returns) predicts grants, bus contents and read returns each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_be, b_be;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable, mem_write_enable;
    logic [1:0]  owner;

    int tests_run = 0;
    int tests_failed = 0;

    // Bus-side memory (written through the DUT) and the model's shadow copy.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    // Model state.
    int          m_wait;
    bit          m_locked;
    bit          m_pa, m_pb;
    logic [31:0] m_ra, m_rb;
    int          exp_win;      // 0 none, 1 A, 2 B

    always #5 clk = ~clk;

    data_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_we(a_we),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be), .b_we(b_we),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_enable(mem_byte_enable), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .owner(owner)
    );

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_enable[i]) mem[mem_address[9:2]][8*i +: 8] <= mem_write_data[8*i +: 8];
            end
        end
    end

    task automatic drive_idle();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_lock = 0;
    endtask

    task automatic model_reset();
        m_wait = 0; m_locked = 0; m_pa = 0; m_pb = 0; m_ra = 0; m_rb = 0;
    endtask

    // Wait for the sampling point and decide who should own the bus.
    task automatic settle();
        @(negedge clk);
        if (b_req && (m_locked || m_wait >= LIMIT)) exp_win = 2;
        else if (a_req) exp_win = 1;
        else if (b_req) exp_win = 2;
        else exp_win = 0;
    endtask

    task automatic shadow_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) ref_mem[addr[9:2]][8*i +: 8] = data[8*i +: 8];
        end
    endtask

    // Apply the transaction accepted this cycle to the model, then move to
    // just after the edge where new stimulus is driven.
    task automatic advance();
        @(posedge clk);
        m_pa = (exp_win == 1) && !a_we;
        m_pb = (exp_win == 2) && !b_we;
        if (m_pa) m_ra = ref_mem[a_addr[9:2]];
        if (m_pb) m_rb = ref_mem[b_addr[9:2]];
        if (exp_win == 1 && a_we) shadow_write(a_addr, a_wdata, a_be);
        if (exp_win == 2 && b_we) shadow_write(b_addr, b_wdata, b_be);
        if (exp_win == 2) begin
            m_wait = 0; m_locked = b_lock;
        end else if (!b_req) begin
            m_wait = 0; m_locked = 0;
        end else begin
            m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        drive_idle();
        a_req = 1; b_req = 1; a_addr = 32'h10; b_addr = 32'h20;
        @(negedge clk);
        tests_run++;
        if ({a_gnt, b_gnt, owner} !== 4'b0) begin
            tests_failed++; $display("FAIL reset_gnt: got a=%b b=%b owner=%b want all 0", a_gnt, b_gnt, owner);
        end
        tests_run++;
        if ({mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable} !== 70'd0) begin
            tests_failed++; $display("FAIL reset_mem: got addr=%h re=%b we=%b want 0", mem_address, mem_read_enable, mem_write_enable);
        end
        tests_run++;
        if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== 66'd0) begin
            tests_failed++; $display("FAIL reset_rdata: got av=%b bv=%b ad=%h bd=%h want 0", a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        @(posedge clk); #1;
        reset = 1;
        drive_idle();
        model_reset();
        $display("[TB] reset checked");
    endtask

    task automatic test_read_pass();
        a_req = 1; a_we = 0; a_addr = 32'h100; a_be = 4'hF;
        settle();
        tests_run++;
        if (a_gnt !== 1'b1 || owner !== 2'b01 || mem_read_enable !== 1'b1 || mem_address !== 32'h100) begin
            tests_failed++; $display("FAIL read_grant: got gnt=%b owner=%b re=%b addr=%h want 1 01 1 00000100", a_gnt, owner, mem_read_enable, mem_address);
        end
        advance();
        drive_idle();
        settle();
        tests_run++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL read_return: got rvalid=%b rdata=%h want 1 deadbeef", a_rvalid, a_rdata);
        end
        tests_run++;
        if (b_rvalid !== 1'b0) begin
            tests_failed++; $display("FAIL read_b_quiet: got b_rvalid=%b want 0", b_rvalid);
        end
        advance();
        settle();
        tests_run++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL read_pulse: got rvalid=%b rdata=%h want 0 deadbeef", a_rvalid, a_rdata);
        end
        advance();
        $display("[TB] read pass-through checked");
    endtask

    task automatic test_write_read();
        a_req = 1; a_we = 1; a_addr = 32'h40; a_wdata = 32'h12345678; a_be = 4'hF;
        settle();
        tests_run++;
        if (a_gnt !== 1'b1 || mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 ||
            mem_write_data !== 32'h12345678 || mem_byte_enable !== 4'hF) begin
            tests_failed++; $display("FAIL write_bus: got gnt=%b we=%b re=%b wd=%h be=%h want 1 1 0 12345678 f",
                                     a_gnt, mem_write_enable, mem_read_enable, mem_write_data, mem_byte_enable);
        end
        advance();
        drive_idle();
        b_req = 1; b_we = 0; b_addr = 32'h40; b_be = 4'hF;
        settle();
        tests_run++;
        if (b_gnt !== 1'b1 || owner !== 2'b10 || a_rvalid !== 1'b0) begin
            tests_failed++; $display("FAIL wr_b_grant: got b_gnt=%b owner=%b a_rvalid=%b want 1 10 0", b_gnt, owner, a_rvalid);
        end
        advance();
        drive_idle();
        settle();
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678) begin
            tests_failed++; $display("FAIL wr_b_return: got rvalid=%b rdata=%h want 1 12345678", b_rvalid, b_rdata);
        end
        advance();
        $display("[TB] write then read checked");
    endtask

    task automatic test_idle();
        drive_idle();
        for (int k = 0; k < 5; k++) begin
            settle();
            tests_run++;
            if (owner !== 2'b00 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 ||
                {mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable} !== 70'd0) begin
                tests_failed++; $display("FAIL idle_%0d: got owner=%b av=%b bv=%b addr=%h want quiet bus", k, owner, a_rvalid, b_rvalid, mem_address);
            end
            advance();
        end
        $display("[TB] idle checked");
    endtask

    // Follows test_idle, so B's wait count starts at zero.
    task automatic test_starvation();
        for (int k = 0; k < 27; k++) begin
            a_req = 1; a_we = 0; a_addr = {22'd0, 8'($urandom), 2'b00}; a_be = 4'hF;
            b_req = 1; b_we = 0; b_addr = {22'd0, 8'($urandom), 2'b00}; b_be = 4'hF; b_lock = 0;
            settle();
            tests_run++;
            if ((k % 9 == 8) ? (b_gnt !== 1'b1 || a_gnt !== 1'b0) : (a_gnt !== 1'b1 || b_gnt !== 1'b0)) begin
                tests_failed++; $display("FAIL starve_cycle_%0d: got a_gnt=%b b_gnt=%b want %s", k, a_gnt, b_gnt, (k % 9 == 8) ? "B" : "A");
            end
            advance();
        end
        drive_idle();
        settle();
        advance();
        $display("[TB] starvation pattern checked");
    endtask

    task automatic test_lock();
        // Let B starve so it wins cycle 8 with A still requesting.
        for (int k = 0; k < 11; k++) begin
            a_req = 1; a_we = 0; a_addr = 32'h8; a_be = 4'hF;
            b_req = (k < 10); b_be = 4'hF; b_addr = 32'hC;
            b_we   = (k == 9);
            b_wdata = 32'hCAFE0001;
            b_lock = (k == 8);
            settle();
            if (k >= 8) begin
                tests_run++;
                if ((k < 10) ? (b_gnt !== 1'b1 || a_gnt !== 1'b0) : (a_gnt !== 1'b1 || b_gnt !== 1'b0)) begin
                    tests_failed++; $display("FAIL lock_cycle_%0d: got a_gnt=%b b_gnt=%b want %s", k, a_gnt, b_gnt, (k < 10) ? "B" : "A");
                end
            end
            advance();
        end
        // Lock released by B dropping its request: A gets the bus that cycle.
        drive_idle();
        b_req = 1; b_lock = 1; b_addr = 32'hC; b_be = 4'hF;
        settle();
        tests_run++;
        if (b_gnt !== 1'b1) begin
            tests_failed++; $display("FAIL lock_take: got b_gnt=%b want 1", b_gnt);
        end
        advance();
        drive_idle();
        a_req = 1; a_addr = 32'h4; a_be = 4'hF;
        settle();
        tests_run++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || b_rvalid !== 1'b1 || b_rdata !== 32'hCAFE0001) begin
            tests_failed++; $display("FAIL lock_drop: got a_gnt=%b b_gnt=%b b_rvalid=%b b_rdata=%h want 1 0 1 cafe0001",
                                     a_gnt, b_gnt, b_rvalid, b_rdata);
        end
        advance();
        drive_idle();
        settle();
        advance();
        $display("[TB] lock checked");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            drive_idle();
            a_req = (k < 5); a_addr = 32'h200 + 32'(k * 4); a_be = 4'hF;
            settle();
            tests_run++;
            if (a_gnt !== (k < 5) || a_rvalid !== (k > 0) || (k > 0 && a_rdata !== m_ra)) begin
                tests_failed++; $display("FAIL b2b_%0d: got gnt=%b rvalid=%b rdata=%h want %b %b %h",
                                         k, a_gnt, a_rvalid, a_rdata, (k < 5), (k > 0), m_ra);
            end
            advance();
        end
        $display("[TB] back-to-back reads checked");
    endtask

    task automatic test_random();
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_re, e_we;
        for (int k = 0; k < 400; k++) begin
            a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom);
            a_addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00}; a_wdata = $urandom; a_be = 4'($urandom);
            b_req = ($urandom_range(0, 2) != 0); b_we = 1'($urandom);
            b_addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00}; b_wdata = $urandom; b_be = 4'($urandom);
            b_lock = ($urandom_range(0, 3) == 0);
            settle();
            e_addr = 0; e_wd = 0; e_be = 0; e_re = 0; e_we = 0;
            if (exp_win == 1) begin
                e_addr = a_addr; e_wd = a_wdata; e_be = a_be; e_re = !a_we; e_we = a_we;
            end else if (exp_win == 2) begin
                e_addr = b_addr; e_wd = b_wdata; e_be = b_be; e_re = !b_we; e_we = b_we;
            end
            tests_run++;
            if (a_gnt !== (exp_win == 1) || b_gnt !== (exp_win == 2) || owner !== 2'(exp_win)) begin
                tests_failed++; $display("FAIL rand_grant_%0d: got a=%b b=%b owner=%b want owner=%0d", k, a_gnt, b_gnt, owner, exp_win);
            end
            tests_run++;
            if (mem_address !== e_addr || mem_write_data !== e_wd || mem_byte_enable !== e_be ||
                mem_read_enable !== e_re || mem_write_enable !== e_we) begin
                tests_failed++; $display("FAIL rand_bus_%0d: got addr=%h wd=%h be=%h re=%b we=%b want %h %h %h %b %b",
                                         k, mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable,
                                         e_addr, e_wd, e_be, e_re, e_we);
            end
            tests_run++;
            if (a_rvalid !== m_pa || b_rvalid !== m_pb || a_rdata !== m_ra || b_rdata !== m_rb) begin
                tests_failed++; $display("FAIL rand_ret_%0d: got av=%b ad=%h bv=%b bd=%h want %b %h %b %h",
                                         k, a_rvalid, a_rdata, b_rvalid, b_rdata, m_pa, m_ra, m_pb, m_rb);
            end
            advance();
        end
        drive_idle();
        settle();
        advance();
        $display("[TB] randomized traffic checked");
    endtask

    task automatic test_reset_mid();
        drive_idle();
        a_req = 1; a_addr = 32'h100; a_be = 4'hF;
        #2;
        tests_run++;
        if (a_gnt !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_pre: got a_gnt=%b want 1", a_gnt);
        end
        reset = 0;
        #1;
        tests_run++;
        if (a_gnt !== 1'b0 || owner !== 2'b00 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_now: got gnt=%b owner=%b re=%b we=%b want 0", a_gnt, owner, mem_read_enable, mem_write_enable);
        end
        @(posedge clk); #1;
        tests_run++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'd0 || b_rdata !== 32'd0) begin
            tests_failed++; $display("FAIL midrst_rvalid: got rvalid=%b ad=%h bd=%h want 0", a_rvalid, a_rdata, b_rdata);
        end
        reset = 1;
        model_reset();
        settle();
        tests_run++;
        if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_regrant: got gnt=%b rvalid=%b want 1 0", a_gnt, a_rvalid);
        end
        advance();
        drive_idle();
        settle();
        tests_run++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL midrst_return: got rvalid=%b rdata=%h want 1 deadbeef", a_rvalid, a_rdata);
        end
        advance();
        $display("[TB] mid-operation reset checked");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        mem[64] = 32'hDEADBEEF;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = mem[i];
        end
        model_reset();
        exp_win = 0;
        test_reset();
        test_read_pass();
        test_write_read();
        test_idle();
        test_starvation();
        test_lock();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
